// File: rtl/genie_merge.sv
// genie_merge: packet-aware N-to-1 valid/ready merge.
//
// Round-robin arbitration among N input streams. The grant is held on one
// input from its first beat until that packet's end-of-packet beat transfers.
// Winning beats pass through a single registered output stage. Each beat is
// tagged with the index of the input that supplied it.
//
// Parameters:
//   N         number of inputs (>= 1)
//   WIDTH     data width per stream
//   SRC_WIDTH width of the source-index tag
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   i_data   input i data at [i*WIDTH +: WIDTH]
//   i_eop    per-input end-of-packet, qualified by i_valid
//   i_valid  per-input valid
//   o_ready  per-input ready (one-hot or zero)
//   o_data   registered output data
//   o_eop    registered output end-of-packet
//   o_src    index of the input that supplied the current output beat
//   o_valid  registered output valid
//   i_ready  downstream ready
module genie_merge #(
   parameter int N         = 2,
   parameter int WIDTH     = 1,
   parameter int SRC_WIDTH = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N*WIDTH-1:0]   i_data,
   input  logic [N-1:0]         i_eop,
   input  logic [N-1:0]         i_valid,
   output logic [N-1:0]         o_ready,
   output logic [WIDTH-1:0]     o_data,
   output logic                 o_eop,
   output logic [SRC_WIDTH-1:0] o_src,
   output logic                 o_valid,
   input  logic                 i_ready
);

   // The pointer starts at the highest index so input 0 has first priority.
   localparam logic [SRC_WIDTH-1:0] LAST_RST = SRC_WIDTH'(N - 1);

   logic                 o_valid_q, o_valid_d;
   logic [WIDTH-1:0]     o_data_q,  o_data_d;
   logic                 o_eop_q,   o_eop_d;
   logic [SRC_WIDTH-1:0] o_src_q,   o_src_d;
   logic                 lock_q,    lock_d;
   logic [SRC_WIDTH-1:0] lk_q,      lk_d;
   logic [SRC_WIDTH-1:0] last_q,    last_d;

   logic                 can_load;
   logic [SRC_WIDTH-1:0] gnt;
   logic                 gnt_vld;
   logic [N-1:0]         gnt_oh;
   logic                 xfer;
   logic [WIDTH-1:0]     sel_data;
   logic                 sel_eop;

   // Gating with reset_n keeps every o_ready low while reset is held, so
   // nothing upstream sees a handshake the register cannot capture.
   assign can_load = reset_n && (!o_valid_q || i_ready);

   // Grant selection. Unlocked, the scan order is last+1, last+2, ... mod N.
   // Two descending passes express that without modulo arithmetic: the first
   // picks the lowest valid index <= last, the second overrides it with the
   // lowest valid index > last when one exists.
   // NOTE: every signal written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      gnt     = lk_q;
      gnt_vld = 1'b0;
      if (lock_q) begin
         gnt     = lk_q;
         gnt_vld = 1'b1;
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (i_valid[i] && (i <= int'(last_q))) begin
               gnt     = SRC_WIDTH'(i);
               gnt_vld = 1'b1;
            end
         end
         for (int i = N - 1; i >= 0; i--) begin
            if (i_valid[i] && (i > int'(last_q))) begin
               gnt     = SRC_WIDTH'(i);
               gnt_vld = 1'b1;
            end
         end
      end
   end

   assign gnt_oh  = gnt_vld ? (N'(1) << gnt) : '0;
   assign o_ready = can_load ? gnt_oh : '0;
   // A locked grant may point at an idle input; only a real valid transfers.
   assign xfer    = |(i_valid & o_ready);

   // Select the granted input's beat with an AND-OR mux.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         sel_data = sel_data | (i_data[i*WIDTH +: WIDTH] & {WIDTH{gnt_oh[i]}});
      end
   end
   assign sel_eop = |(i_eop & gnt_oh);

   always_comb begin
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      o_eop_d   = o_eop_q;
      o_src_d   = o_src_q;
      lock_d    = lock_q;
      lk_d      = lk_q;
      last_d    = last_q;
      if (xfer) begin
         o_valid_d = 1'b1;
         o_data_d  = sel_data;
         o_eop_d   = sel_eop;
         o_src_d   = gnt;
         if (sel_eop) begin
            // Packet complete: release and advance the round-robin pointer.
            lock_d = 1'b0;
            last_d = gnt;
         end else begin
            lock_d = 1'b1;
            lk_d   = gnt;
         end
      end else if (can_load) begin
         // Register was empty or drained this cycle and nothing refills it.
         o_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its next value from the same pre-edge snapshot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         o_eop_q   <= 1'b0;
         o_src_q   <= '0;
         lock_q    <= 1'b0;
         lk_q      <= '0;
         last_q    <= LAST_RST;
      end else begin
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         o_eop_q   <= o_eop_d;
         o_src_q   <= o_src_d;
         lock_q    <= lock_d;
         lk_q      <= lk_d;
         last_q    <= last_d;
      end
   end

   assign o_valid = o_valid_q;
   assign o_data  = o_data_q;
   assign o_eop   = o_eop_q;
   assign o_src   = o_src_q;

endmodule

// File: tb/tb_genie_merge.sv
// Directed testbench for genie_merge with N=4, WIDTH=8.
// Inputs change 1 time unit after each rising edge; outputs and o_ready are
// sampled 1 time unit later, well away from the next edge.
module tb_genie_merge;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N*W-1:0]  i_data;
   logic [N-1:0]    i_eop;
   logic [N-1:0]    i_valid;
   logic [N-1:0]    o_ready;
   logic [W-1:0]    o_data;
   logic            o_eop;
   logic [SW-1:0]   o_src;
   logic            o_valid;
   logic            i_ready;

   int n_pass  = 0;
   int n_total = 0;

   genie_merge #(.N(N), .WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .i_data  (i_data),
      .i_eop   (i_eop),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_eop   (o_eop),
      .o_src   (o_src),
      .o_valid (o_valid),
      .i_ready (i_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic lane(input int i, input logic [W-1:0] d, input logic e);
      i_data[i*W +: W] = d;
      i_eop[i]         = e;
   endtask

   // Check the registered output beat in one call.
   task automatic out(input string tag, input logic v, input logic [W-1:0] d,
                      input logic e, input logic [SW-1:0] s);
      check({tag, "_valid"}, 32'(o_valid), 32'(v));
      check({tag, "_data"},  32'(o_data),  32'(d));
      check({tag, "_eop"},   32'(o_eop),   32'(e));
      check({tag, "_src"},   32'(o_src),   32'(s));
   endtask

   initial begin
      reset_n = 1'b0;
      i_data  = '0;
      i_eop   = '0;
      i_valid = 4'b1111;
      i_ready = 1'b1;

      // ---------------- reset ----------------
      tick();
      tick();
      check("rst_valid", 32'(o_valid), 32'h0);
      check("rst_ready", 32'(o_ready), 32'h0);
      reset_n = 1'b1;
      i_valid = 4'b1010;
      i_eop   = 4'b1010;
      settle();
      check("rst_first_ready", 32'(o_ready), 32'h2);
      i_valid = 4'b0000;
      tick();
      check("rst_idle_valid", 32'(o_valid), 32'h0);

      // ---------------- single stream on input 2 ----------------
      i_valid = 4'b0100;
      lane(2, 8'hA0, 1'b0);
      settle();
      check("ss_ready0", 32'(o_ready), 32'h4);
      tick();
      lane(2, 8'hA1, 1'b0);
      settle();
      out("ss_d0", 1'b1, 8'hA0, 1'b0, 2'd2);
      tick();
      lane(2, 8'hA2, 1'b1);
      settle();
      out("ss_d1", 1'b1, 8'hA1, 1'b0, 2'd2);
      tick();
      i_valid = 4'b0000;
      settle();
      out("ss_d2", 1'b1, 8'hA2, 1'b1, 2'd2);
      tick();
      check("ss_drain", 32'(o_valid), 32'h0);

      // ---------------- round robin, inputs 1 and 3 ----------------
      // Pointer sits at 2 after the last packet, so input 3 wins first.
      i_valid = 4'b1010;
      lane(1, 8'h11, 1'b1);
      lane(3, 8'h33, 1'b1);
      tick();
      out("rr0", 1'b1, 8'h33, 1'b1, 2'd3);
      tick();
      out("rr1", 1'b1, 8'h11, 1'b1, 2'd1);
      tick();
      out("rr2", 1'b1, 8'h33, 1'b1, 2'd3);
      tick();
      out("rr3", 1'b1, 8'h11, 1'b1, 2'd1);
      i_valid = 4'b0000;
      tick();
      check("rr_drain", 32'(o_valid), 32'h0);

      // ---------------- lock on input 0, input 3 waiting ----------------
      i_valid = 4'b0001;
      lane(0, 8'hB0, 1'b0);
      lane(3, 8'hC3, 1'b1);
      settle();
      check("lk_ready_b0", 32'(o_ready), 32'h1);
      tick();
      i_valid = 4'b1001;
      lane(0, 8'hB1, 1'b0);
      settle();
      check("lk_ready_b1", 32'(o_ready), 32'h1);
      out("lk_b0", 1'b1, 8'hB0, 1'b0, 2'd0);
      tick();
      i_valid = 4'b1000;
      settle();
      check("lk_gap1_ready", 32'(o_ready), 32'h1);
      out("lk_b1", 1'b1, 8'hB1, 1'b0, 2'd0);
      tick();
      settle();
      check("lk_gap2_ready", 32'(o_ready), 32'h1);
      check("lk_gap2_valid", 32'(o_valid), 32'h0);
      tick();
      i_valid = 4'b1001;
      lane(0, 8'hB2, 1'b0);
      settle();
      check("lk_ready_b2", 32'(o_ready), 32'h1);
      tick();
      lane(0, 8'hB3, 1'b1);
      settle();
      check("lk_ready_b3", 32'(o_ready), 32'h1);
      out("lk_b2", 1'b1, 8'hB2, 1'b0, 2'd0);
      tick();
      i_valid = 4'b1000;
      settle();
      check("lk_switch_ready", 32'(o_ready), 32'h8);
      out("lk_b3", 1'b1, 8'hB3, 1'b1, 2'd0);
      tick();
      i_valid = 4'b0000;
      settle();
      out("lk_c3", 1'b1, 8'hC3, 1'b1, 2'd3);
      tick();

      // ---------------- backpressure on input 2 stream ----------------
      i_valid = 4'b0100;
      lane(2, 8'hE0, 1'b0);
      tick();
      lane(2, 8'hE1, 1'b0);
      settle();
      out("bp_e0", 1'b1, 8'hE0, 1'b0, 2'd2);
      tick();
      lane(2, 8'hE2, 1'b0);
      i_ready = 1'b0;
      settle();
      check("bp_ready0", 32'(o_ready), 32'h0);
      out("bp_hold0", 1'b1, 8'hE1, 1'b0, 2'd2);
      tick();
      settle();
      check("bp_ready1", 32'(o_ready), 32'h0);
      out("bp_hold1", 1'b1, 8'hE1, 1'b0, 2'd2);
      tick();
      settle();
      check("bp_ready2", 32'(o_ready), 32'h0);
      out("bp_hold2", 1'b1, 8'hE1, 1'b0, 2'd2);
      tick();
      i_ready = 1'b1;
      settle();
      check("bp_release_ready", 32'(o_ready), 32'h4);
      out("bp_e1", 1'b1, 8'hE1, 1'b0, 2'd2);
      tick();
      lane(2, 8'hE3, 1'b1);
      settle();
      out("bp_e2", 1'b1, 8'hE2, 1'b0, 2'd2);
      tick();
      i_valid = 4'b0000;
      settle();
      out("bp_e3", 1'b1, 8'hE3, 1'b1, 2'd2);
      tick();
      check("bp_drain", 32'(o_valid), 32'h0);

      // ---------------- reset while locked on input 2 ----------------
      i_valid = 4'b0100;
      lane(2, 8'hF0, 1'b0);
      tick();
      lane(2, 8'hF1, 1'b0);
      settle();
      out("mr_f0", 1'b1, 8'hF0, 1'b0, 2'd2);
      #2;
      reset_n = 1'b0;
      #1;
      check("mr_async_valid", 32'(o_valid), 32'h0);
      tick();
      reset_n = 1'b1;
      i_valid = 4'b0101;
      lane(0, 8'h70, 1'b1);
      lane(2, 8'h72, 1'b1);
      settle();
      check("mr_ready", 32'(o_ready), 32'h1);
      tick();
      i_valid = 4'b0000;
      settle();
      out("mr_first", 1'b1, 8'h70, 1'b1, 2'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/genie_merge.md
# genie_merge

Packet-aware N-to-1 merge: the converging counterpart of the valid/ready split/fork blocks on the same interconnect. It arbitrates among N valid/ready input streams with a round-robin policy. It holds the grant on one input from its first beat until that packet's end-of-packet beat transfers. Winning beats pass through a single registered output stage tagged with the source index.

## Interface
Parameters:
- N, 2, number of inputs (N >= 1)
- WIDTH, 1, data width per stream
- SRC_WIDTH, max(1, $clog2(N)), width of source-index tag

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_data  in  N*WIDTH  input i data at [i*WIDTH +: WIDTH]
- i_eop  in  N  end-of-packet flag per input, qualified by i_valid
- i_valid  in  N  per-input valid
- o_ready  out  N  per-input ready (at most one bit high)
- o_data  out  WIDTH  registered output data
- o_eop  out  1  registered end-of-packet
- o_src  out  SRC_WIDTH  index of input that supplied current output beat
- o_valid  out  1  registered output valid
- i_ready  in  1  downstream ready

## Operation
- State:
  - output register (o_valid, o_data, o_eop, o_src);
  - lock flag plus locked index `lk`;
  - round-robin pointer `last` (index of the most recently completed packet).
- Reset values: o_valid=0, o_data=0, o_eop=0, o_src=0, lock=0, lk=0, last=N-1, so input 0 has first priority.
- can_load = !o_valid || i_ready. The output register accepts a beat when empty or drained this cycle.
- Grant selection:
  - Locked: grant = lk, whether or not i_valid[lk] is set.
  - Unlocked: grant = first i with i_valid[i]=1, scanning last+1, last+2, … wrapping mod N. If no input is valid, there is no grant.
- o_ready[i] = can_load && grant valid && grant==i. All other bits are 0. o_ready may depend on i_valid; i_valid must never depend on o_ready.
- Transfer on input i: i_valid[i] && o_ready[i]. On transfer:
  - o_data/o_eop load from input i; o_src=i; o_valid=1.
  - If i_eop[i]=0: lock=1, lk=i.
  - If i_eop[i]=1: lock=0, last=i. A single-beat packet never locks.
- If can_load and there is no transfer: o_valid becomes 0 when i_ready=1 drained the beat. Otherwise the register holds.
- Locked source deasserts valid mid-packet: the output idles. No other input is granted until the locked packet's eop beat transfers.
- While o_valid=1 && i_ready=0: o_data, o_eop and o_src are held stable and all o_ready are 0.
- N=1: behaves as a one-stage registered pipe; o_src is always 0.
- Asynchronous reset mid-packet: all state returns to reset values immediately. Any partially forwarded packet is abandoned with no eop. Upstream and downstream must also be reset.

## Timing
- Latency: input transfer at cycle t puts the beat on the output with o_valid=1 from cycle t+1.
- Throughput: one beat per cycle while i_ready=1, including across packet boundaries.
- Zero-bubble source switch: eop transfers from input a at cycle t, another input is granted at cycle t+1.
- Fairness: with all N inputs continuously offering packets, each input is granted exactly once per N packets.
- Lock and pointer updates take effect the cycle after the transfer. Grant and o_ready are combinational from registered state and i_valid.
- No combinational path from i_ready to o_valid or o_data. The only combinational path from i_ready is to o_ready, via can_load.

## Test plan
- Reset: hold reset_n=0, drive i_valid=all ones.
  - Expected during reset: o_valid=0, o_ready=0.
  - After release, N=4, i_valid=4'b1010: o_ready=4'b0010 on the first cycle.
- Single stream: N=4, input 2 sends 3-beat packet D0,D1,D2 (eop on D2), i_ready=1.
  - Output shows D0,D1,D2 on cycles t+1..t+3 with o_src=2, o_eop only on D2.
- Round robin: N=4, inputs 1 and 3 each continuously offer single-beat packets, i_ready=1.
  - o_src sequence is 1,3,1,3,… with o_valid=1 every cycle.
- Lock:
  - Stimulus: input 0 sends 4-beat packet with i_valid[0]=0 for two cycles after beat 2; input 3 is valid throughout.
  - Expected: o_ready[3]=0 until beat 4 (eop) of input 0 transfers, then o_ready[3]=1 next cycle, then o_src=3.
- Backpressure: during a stream, hold i_ready=0 for 3 cycles.
  - Expected: o_data/o_eop/o_src stable, o_ready=0.
  - After release: the beat sequence resumes with no loss or duplication.
- Reset mid-packet: pull reset_n low while locked on input 2.
  - Expected: o_valid=0 asynchronously.
  - After release, inputs 0 and 2 both valid: input 0 is granted first.
